// File: rtl/minn_multi_antenna_path.sv
// minn_multi_antenna_path: multi-antenna Minn quarter-lag correlation/energy taps with runtime quarter length.
// Define MINN_CORR_IMAG_EN to add the windowed imaginary correlation taps.
module minn_multi_antenna_path #(
    parameter int NUM_ANT         = 2,
    parameter int INPUT_WIDTH     = 12,
    parameter int MAX_QUARTER_LEN = 512,
    parameter int LEN_WIDTH       = $clog2(MAX_QUARTER_LEN + 1),
    parameter int ANT_GROWTH      = (NUM_ANT <= 1) ? 0 : $clog2(NUM_ANT),
    parameter int CORR_WIDTH      = 2 * INPUT_WIDTH + 1 + LEN_WIDTH + ANT_GROWTH,
    parameter int ENERGY_WIDTH    = CORR_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_load,
    input  logic [LEN_WIDTH-1:0]           cfg_quarter_len,
    output logic                           cfg_error,
    input  logic                           in_valid,
    input  logic [NUM_ANT*INPUT_WIDTH-1:0] in_i,
    input  logic [NUM_ANT*INPUT_WIDTH-1:0] in_q,
    output logic [CORR_WIDTH-1:0]          corr_recent,
    output logic [CORR_WIDTH-1:0]          corr_previous,
    output logic [ENERGY_WIDTH-1:0]        energy_recent,
    output logic [ENERGY_WIDTH-1:0]        energy_previous,
    output logic [ENERGY_WIDTH-1:0]        energy_previous2,
    output logic                           taps_valid,
    output logic                           running
`ifdef MINN_CORR_IMAG_EN
    ,
    output logic [CORR_WIDTH-1:0]          corr_recent_q,
    output logic [CORR_WIDTH-1:0]          corr_previous_q
`endif
);
    localparam int AW = (MAX_QUARTER_LEN > 1) ? $clog2(MAX_QUARTER_LEN) : 1;
    localparam int KW = LEN_WIDTH + 2;
    localparam int CW = CORR_WIDTH;
    localparam int EW = ENERGY_WIDTH;

    typedef enum logic {FILL, RUN} state_t;
    state_t state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [KW-1:0] k_q, k_d, k3;
    logic [AW-1:0] wp_q, wp_d, rd;
    logic err_q, err_d, tv_q, tv_d, legal, old_ok;
    int rd_i;
    logic signed [CW-1:0] xi, xq, di, dq;
    logic signed [CW-1:0] c_q, c_d, cp_q, cp_d, p_new, p_old, c_old;
    logic signed [EW-1:0] e_q, e_d, ep_q, ep_d, ep2_q, ep2_d, w_new, w_old, e_old, e2_old;

    logic signed [INPUT_WIDTH-1:0] xi_mem [NUM_ANT][MAX_QUARTER_LEN];
    logic signed [INPUT_WIDTH-1:0] xq_mem [NUM_ANT][MAX_QUARTER_LEN];
    logic signed [CW-1:0] p_mem [MAX_QUARTER_LEN];
    logic signed [CW-1:0] c_mem [MAX_QUARTER_LEN];
    logic signed [EW-1:0] w_mem [MAX_QUARTER_LEN];
    logic signed [EW-1:0] e_mem [MAX_QUARTER_LEN];
    logic signed [EW-1:0] e2_mem [MAX_QUARTER_LEN];
`ifdef MINN_CORR_IMAG_EN
    logic signed [CW-1:0] cq_q, cq_d, cqp_q, cqp_d, pq_new, pq_old, cq_old;
    logic signed [CW-1:0] pq_mem [MAX_QUARTER_LEN];
    logic signed [CW-1:0] cq_mem [MAX_QUARTER_LEN];
`endif

    always_comb begin
        legal  = (cfg_quarter_len != '0) && (cfg_quarter_len <= LEN_WIDTH'(MAX_QUARTER_LEN));
        k3     = KW'(len_q) * KW'(3);
        // Everything read back at age L is zero until L samples have been taken since restart.
        old_ok = k_q >= KW'(len_q);
        rd_i   = int'(wp_q) - int'(len_q);
        rd     = AW'((rd_i < 0) ? rd_i + MAX_QUARTER_LEN : rd_i);
        xi = '0;
        xq = '0;
        di = '0;
        dq = '0;
        p_new = '0;
        w_new = '0;
`ifdef MINN_CORR_IMAG_EN
        pq_new = '0;
`endif
        for (int a = 0; a < NUM_ANT; a++) begin
            xi = CW'(signed'(in_i[a*INPUT_WIDTH +: INPUT_WIDTH]));
            xq = CW'(signed'(in_q[a*INPUT_WIDTH +: INPUT_WIDTH]));
            di = old_ok ? CW'(xi_mem[a][rd]) : '0;
            dq = old_ok ? CW'(xq_mem[a][rd]) : '0;
            p_new = p_new + di * xi + dq * xq;
            w_new = w_new + EW'(xi * xi + xq * xq);
`ifdef MINN_CORR_IMAG_EN
            pq_new = pq_new + di * xq - dq * xi;
`endif
        end
        p_old  = old_ok ? p_mem[rd] : '0;
        c_old  = old_ok ? c_mem[rd] : '0;
        w_old  = old_ok ? w_mem[rd] : '0;
        e_old  = old_ok ? e_mem[rd] : '0;
        e2_old = old_ok ? e2_mem[rd] : '0;
        state_d = state_q;
        len_d   = len_q;
        k_d     = k_q;
        wp_d    = wp_q;
        err_d   = err_q;
        tv_d    = 1'b0;
        c_d     = c_q;
        cp_d    = cp_q;
        e_d     = e_q;
        ep_d    = ep_q;
        ep2_d   = ep2_q;
`ifdef MINN_CORR_IMAG_EN
        pq_old = old_ok ? pq_mem[rd] : '0;
        cq_old = old_ok ? cq_mem[rd] : '0;
        cq_d   = cq_q;
        cqp_d  = cqp_q;
`endif
        if (cfg_load && legal) begin
            state_d = FILL;
            len_d   = cfg_quarter_len;
            k_d     = '0;
            err_d   = 1'b0;
            c_d     = '0;
            cp_d    = '0;
            e_d     = '0;
            ep_d    = '0;
            ep2_d   = '0;
`ifdef MINN_CORR_IMAG_EN
            cq_d    = '0;
            cqp_d   = '0;
`endif
        end else if (cfg_load) begin
            err_d = 1'b1;
        end else if (in_valid) begin
            k_d     = (k_q >= k3) ? k_q : k_q + KW'(1);
            wp_d    = (wp_q == AW'(MAX_QUARTER_LEN - 1)) ? '0 : wp_q + AW'(1);
            tv_d    = k_d >= k3;
            state_d = (k_d >= k3) ? RUN : state_q;
            c_d     = c_q + p_new - p_old;
            cp_d    = c_old;
            e_d     = e_q + w_new - w_old;
            ep_d    = e_old;
            ep2_d   = e2_old;
`ifdef MINN_CORR_IMAG_EN
            cq_d    = cq_q + pq_new - pq_old;
            cqp_d   = cq_old;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            len_q   <= LEN_WIDTH'(MAX_QUARTER_LEN);
            k_q     <= '0;
            wp_q    <= '0;
            err_q   <= 1'b0;
            tv_q    <= 1'b0;
            c_q     <= '0;
            cp_q    <= '0;
            e_q     <= '0;
            ep_q    <= '0;
            ep2_q   <= '0;
`ifdef MINN_CORR_IMAG_EN
            cq_q    <= '0;
            cqp_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            k_q     <= k_d;
            wp_q    <= wp_d;
            err_q   <= err_d;
            tv_q    <= tv_d;
            c_q     <= c_d;
            cp_q    <= cp_d;
            e_q     <= e_d;
            ep_q    <= ep_d;
            ep2_q   <= ep2_d;
`ifdef MINN_CORR_IMAG_EN
            cq_q    <= cq_d;
            cqp_q   <= cqp_d;
`endif
        end
    end

    // e2_mem holds E(n-L) so that reading it at age L yields E(n-2L).
    always_ff @(posedge clk) begin
        if (in_valid && !cfg_load) begin
            for (int a = 0; a < NUM_ANT; a++) begin
                xi_mem[a][wp_q] <= in_i[a*INPUT_WIDTH +: INPUT_WIDTH];
                xq_mem[a][wp_q] <= in_q[a*INPUT_WIDTH +: INPUT_WIDTH];
            end
            p_mem[wp_q]  <= p_new;
            c_mem[wp_q]  <= c_d;
            w_mem[wp_q]  <= w_new;
            e_mem[wp_q]  <= e_d;
            e2_mem[wp_q] <= e_old;
`ifdef MINN_CORR_IMAG_EN
            pq_mem[wp_q] <= pq_new;
            cq_mem[wp_q] <= cq_d;
`endif
        end
    end

    assign cfg_error        = err_q;
    assign taps_valid       = tv_q;
    assign running          = state_q == RUN;
    assign corr_recent      = c_q;
    assign corr_previous    = cp_q;
    assign energy_recent    = e_q;
    assign energy_previous  = ep_q;
    assign energy_previous2 = ep2_q;
`ifdef MINN_CORR_IMAG_EN
    assign corr_recent_q    = cq_q;
    assign corr_previous_q  = cqp_q;
`endif
endmodule
